// File: rtl/bsg_manycore_pod_reset_tag_gen.sv
// bsg_manycore_pod_reset_tag_gen
// Serial bsg_tag packet generator for the per-pod reset clients. After reset it
// clears every pod client, asserts every pod reset, holds, then releases them in
// pod order. After that it serves host writes of a single pod's reset payload.
module bsg_manycore_pod_reset_tag_gen #(
  parameter int unsigned num_pods_x_p        = 2,
  parameter int unsigned num_pods_y_p        = 1,
  parameter int unsigned tag_els_p           = 4,
  parameter int unsigned tag_lg_width_p      = 1,
  parameter int unsigned tag_node_offset_p   = 0,
  parameter int unsigned payload_width_p     = 1,
  parameter int unsigned reset_hold_cycles_p = 16,
  parameter int unsigned idle_gap_p          = 4,
  localparam int unsigned NumPods = num_pods_x_p * num_pods_y_p,
  localparam int unsigned PodW    = (NumPods > 1) ? $clog2(NumPods) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cmd_v_i,
  input  logic [PodW-1:0]            cmd_pod_id_i,
  input  logic [payload_width_p-1:0] cmd_data_i,
  output logic                       cmd_ready_o,
  output logic                       tag_data_o,
  output logic                       init_done_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned IdW      = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
  // start + node id + data_not_reset + length + payload
  localparam int unsigned PktW     = 2 + IdW + tag_lg_width_p + payload_width_p;
  localparam int unsigned BitCntW  = $clog2(PktW);
  localparam int unsigned GapCntW  = (idle_gap_p > 1) ? $clog2(idle_gap_p) : 1;
  localparam int unsigned HoldCntW = (reset_hold_cycles_p > 1) ? $clog2(reset_hold_cycles_p) : 1;
  localparam int unsigned DnrPos   = 1 + IdW;
  localparam int unsigned LenLsb   = 2 + IdW;
  localparam int unsigned PayLsb   = 2 + IdW + tag_lg_width_p;

  localparam logic [BitCntW-1:0]        BitLast  = BitCntW'(PktW - 1);
  localparam logic [GapCntW-1:0]        GapLast  = GapCntW'(idle_gap_p - 1);
  localparam logic [HoldCntW-1:0]       HoldLast = HoldCntW'(reset_hold_cycles_p - 1);
  localparam logic [PodW-1:0]           PodLast  = PodW'(NumPods - 1);
  localparam logic [tag_lg_width_p-1:0] LenVal   = tag_lg_width_p'(payload_width_p);

  typedef enum logic [2:0] {
    StLead, StClr, StAssert, StHold, StDeassert, StIdle, StSend, StGap
  } state_e;

  state_e                     r_state, w_state_next;
  logic [BitCntW-1:0]         r_bit_cnt, w_bit_cnt_next;
  logic [GapCntW-1:0]         r_gap_cnt, w_gap_cnt_next;
  logic [HoldCntW-1:0]        r_hold_cnt, w_hold_cnt_next;
  logic [PodW-1:0]            r_pod, w_pod_next;
  // Power-on packet states alternate between a packet phase and a gap phase.
  logic                       r_in_gap, w_in_gap_next;
  logic                       r_init_done, w_init_done_next;
  logic                       r_err, w_err_next;
  logic                       r_tag;
  logic [PktW-1:0]            r_shift;

  logic                       w_load;
  logic                       w_shift;
  logic                       w_cmd_ready;
  logic                       w_busy;
  logic                       w_cmd_id_ok;
  logic [PodW-1:0]            w_ld_pod;
  logic [IdW-1:0]             w_ld_id;
  logic                       w_ld_dnr;
  logic [payload_width_p-1:0] w_ld_payload;
  logic [PktW-1:0]            w_packet;

  assign w_cmd_id_ok = (32'(cmd_pod_id_i) < NumPods);
  assign w_ld_id     = IdW'(tag_node_offset_p + 32'(w_ld_pod));

  // Assemble the packet to load; bit 0 goes out first.
  always_comb begin
    w_packet                                = '0;
    w_packet[0]                             = 1'b1;
    w_packet[1 +: IdW]                      = w_ld_id;
    w_packet[DnrPos]                        = w_ld_dnr;
    w_packet[LenLsb +: tag_lg_width_p]      = LenVal;
    w_packet[PayLsb +: payload_width_p]     = w_ld_payload;
  end

  // Sequencer next-state, counters and combinational outputs.
  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_gap_cnt_next   = r_gap_cnt;
    w_hold_cnt_next  = r_hold_cnt;
    w_pod_next       = r_pod;
    w_in_gap_next    = r_in_gap;
    w_init_done_next = r_init_done;
    w_err_next       = 1'b0;
    w_load           = 1'b0;
    w_shift          = 1'b0;
    w_cmd_ready      = 1'b0;
    w_busy           = 1'b0;

    unique case (r_state)
      StLead: begin
        if (r_gap_cnt == GapLast) begin
          w_state_next   = StClr;
          w_pod_next     = '0;
          w_in_gap_next  = 1'b0;
          w_bit_cnt_next = '0;
          w_gap_cnt_next = '0;
          w_load         = 1'b1;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 1'b1;
        end
      end

      StClr, StAssert, StDeassert: begin
        w_busy = 1'b1;
        if (!r_in_gap) begin
          if (r_bit_cnt == BitLast) begin
            w_in_gap_next  = 1'b1;
            w_gap_cnt_next = '0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_shift        = 1'b1;
          end
        end else if (r_gap_cnt != GapLast) begin
          w_gap_cnt_next = r_gap_cnt + 1'b1;
        end else if (r_pod != PodLast) begin
          w_pod_next     = r_pod + 1'b1;
          w_in_gap_next  = 1'b0;
          w_bit_cnt_next = '0;
          w_load         = 1'b1;
        end else if (r_state == StClr) begin
          w_state_next   = StAssert;
          w_pod_next     = '0;
          w_in_gap_next  = 1'b0;
          w_bit_cnt_next = '0;
          w_load         = 1'b1;
        end else if (r_state == StAssert) begin
          w_state_next    = StHold;
          w_hold_cnt_next = '0;
        end else begin
          w_state_next     = StIdle;
          w_init_done_next = 1'b1;
        end
      end

      StHold: begin
        if (r_hold_cnt == HoldLast) begin
          w_state_next   = StDeassert;
          w_pod_next     = '0;
          w_in_gap_next  = 1'b0;
          w_bit_cnt_next = '0;
          w_load         = 1'b1;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end

      StIdle: begin
        w_cmd_ready = 1'b1;
        if (cmd_v_i) begin
          if (w_cmd_id_ok) begin
            w_state_next   = StSend;
            w_bit_cnt_next = '0;
            w_load         = 1'b1;
          end else begin
            // Out-of-range pod: swallow the command and flag it.
            w_err_next = 1'b1;
          end
        end
      end

      StSend: begin
        w_busy = 1'b1;
        if (r_bit_cnt == BitLast) begin
          w_state_next   = StGap;
          w_gap_cnt_next = '0;
        end else begin
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          w_shift        = 1'b1;
        end
      end

      StGap: begin
        w_busy = 1'b1;
        if (r_gap_cnt == GapLast) begin
          w_state_next = StIdle;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 1'b1;
        end
      end
    endcase
  end

  // Packet contents follow the state being entered when a packet is loaded.
  always_comb begin
    w_ld_pod     = (w_state_next == StSend) ? cmd_pod_id_i : w_pod_next;
    w_ld_dnr     = 1'b1;
    w_ld_payload = '0;
    case (w_state_next)
      StClr: begin
        w_ld_dnr     = 1'b0;
        w_ld_payload = '1;
      end
      StAssert: w_ld_payload = payload_width_p'(1);
      StSend:   w_ld_payload = cmd_data_i;
      default:  w_ld_payload = '0;
    endcase
  end

  // State, counters and the registered serial output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= StLead;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_pod       <= '0;
      r_in_gap    <= 1'b0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_tag       <= 1'b0;
      r_shift     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_pod       <= w_pod_next;
      r_in_gap    <= w_in_gap_next;
      r_init_done <= w_init_done_next;
      r_err       <= w_err_next;
      if (w_load) begin
        r_tag   <= w_packet[0];
        r_shift <= w_packet >> 1;
      end else if (w_shift) begin
        r_tag   <= r_shift[0];
        r_shift <= r_shift >> 1;
      end else begin
        r_tag <= 1'b0;
      end
    end
  end

  assign tag_data_o  = r_tag;
  assign cmd_ready_o = w_cmd_ready;
  assign busy_o      = w_busy;
  assign init_done_o = r_init_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_bsg_manycore_pod_reset_tag_gen.sv
// Scoreboard bench: stimulus pushes the expected per-cycle output vector
// {tag, ready, busy, init_done, err}; a negedge monitor pops and compares.
// Configuration: 3x1 pods, 4 tag clients, 1-bit length, 1-bit payload,
// gap 4, hold 10 -> 6-bit packets, 104-cycle power-on sequence.
module tb_bsg_manycore_pod_reset_tag_gen;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       cmd_v_i;
  logic [1:0] cmd_pod_id_i;
  logic [0:0] cmd_data_i;
  logic       cmd_ready_o, tag_data_o, init_done_o, busy_o, err_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Hand-computed packets, bit i is stream bit i:
  // {payload, length=1, data_not_reset, id[1], id[0], start=1}
  logic [5:0] po_tbl [9] = '{
    6'b110001, 6'b110011, 6'b110101,   // clear pods 0..2
    6'b111001, 6'b111011, 6'b111101,   // assert pods 0..2
    6'b011001, 6'b011011, 6'b011101    // deassert pods 0..2
  };

  bsg_manycore_pod_reset_tag_gen #(
    .num_pods_x_p        (3),
    .num_pods_y_p        (1),
    .tag_els_p           (4),
    .tag_lg_width_p      (1),
    .tag_node_offset_p   (0),
    .payload_width_p     (1),
    .reset_hold_cycles_p (10),
    .idle_gap_p          (4)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .cmd_v_i      (cmd_v_i),
    .cmd_pod_id_i (cmd_pod_id_i),
    .cmd_data_i   (cmd_data_i),
    .cmd_ready_o  (cmd_ready_o),
    .tag_data_o   (tag_data_o),
    .init_done_o  (init_done_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Monitor: one expected vector per clock cycle while the queue holds any.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if ({tag_data_o, cmd_ready_o, busy_o, init_done_o, err_o} !== mon_e.v) begin
        n_err++;
        $display("FAIL %s @%0t: tag/rdy/busy/done/err got %b%b%b%b%b want %b", mon_e.name,
                 $time, tag_data_o, cmd_ready_o, busy_o, init_done_o, err_o, mon_e.v);
      end
    end
  end

  task automatic push(input logic [4:0] v, input string name);
    exp_t e;
    e.v    = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic exp_zero(input int n, input logic rdy, input logic busy, input logic done,
                          input string name);
    for (int i = 0; i < n; i++) push({1'b0, rdy, busy, done, 1'b0}, name);
  endtask

  task automatic exp_pkt(input logic [5:0] bits, input logic done, input string name);
    for (int i = 0; i < 6; i++) push({bits[i], 1'b0, 1'b1, done, 1'b0},
                                     $sformatf("%s_b%0d", name, i));
  endtask

  task automatic exp_poweron();
    exp_zero(4, 1'b0, 1'b0, 1'b0, "lead");
    for (int i = 0; i < 9; i++) begin
      exp_pkt(po_tbl[i], 1'b0, $sformatf("po_pkt%0d", i));
      exp_zero(4, 1'b0, 1'b1, 1'b0, $sformatf("po_gap%0d", i));
      if (i == 5) exp_zero(10, 1'b0, 1'b0, 1'b0, "hold");
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one command from an IDLE cycle and queue the expected response.
  task automatic do_cmd(input logic [1:0] pod, input logic data, input logic valid,
                        input logic [5:0] bits, input string name);
    cmd_v_i      = 1'b1;
    cmd_pod_id_i = pod;
    cmd_data_i   = data;
    push(5'b01010, {name, "_accept"});
    if (valid) begin
      exp_pkt(bits, 1'b1, name);
      exp_zero(4, 1'b0, 1'b1, 1'b1, {name, "_gap"});
      wait_cyc(1);
      cmd_v_i = 1'b0;
      wait_cyc(10);
    end else begin
      push(5'b01011, {name, "_err"});
      push(5'b01010, {name, "_after"});
      wait_cyc(1);
      cmd_v_i = 1'b0;
      wait_cyc(2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i      = 1'b1;
    // Command held during the whole power-on sequence.
    cmd_v_i      = 1'b1;
    cmd_pod_id_i = 2'd0;
    cmd_data_i   = 1'b1;
    wait_cyc(3);
    push(5'b00000, "reset_state");
    wait_cyc(1);
    reset_i = 1'b0;
    exp_poweron();
    wait_cyc(104);

    // First IDLE cycle accepts the held command.
    do_cmd(2'd0, 1'b1, 1'b1, 6'b111001, "held_cmd");
    do_cmd(2'd1, 1'b0, 1'b1, 6'b011011, "cmd_pod1_d0");
    do_cmd(2'd2, 1'b1, 1'b1, 6'b111101, "cmd_pod2_d1");
    do_cmd(2'd3, 1'b1, 1'b0, 6'b000000, "cmd_bad_id");
    do_cmd(2'd0, 1'b0, 1'b1, 6'b011001, "cmd_pod0_d0");

    // Reset during the third bit of a SEND.
    cmd_v_i      = 1'b1;
    cmd_pod_id_i = 2'd2;
    cmd_data_i   = 1'b1;
    push(5'b01010, "trunc_accept");
    push(5'b10110, "trunc_b0");
    push(5'b00110, "trunc_b1");
    push(5'b10110, "trunc_b2");
    wait_cyc(1);
    cmd_v_i = 1'b0;
    wait_cyc(2);
    reset_i = 1'b1;
    wait_cyc(1);
    reset_i = 1'b0;
    exp_poweron();
    wait_cyc(104);

    do_cmd(2'd1, 1'b1, 1'b1, 6'b111011, "post_reset_cmd");
    push(5'b01010, "final_idle");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
